// File: rtl/qlf_bram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | qlf_bram_pkg: shared helpers for the asymmetric wide-read BRAM        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package qlf_bram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Bit n set means a write width of n bits maps onto a native TDP36K mode.
    localparam logic [31:0] c_LEGAL_WIDTH_MASK =
        (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 4) | (32'd1 << 8) |
        (32'd1 << 9) | (32'd1 << 16) | (32'd1 << 18);

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit width_legal(input int w);
        return (w >= 0 && w < 32) ? c_LEGAL_WIDTH_MASK[w[4:0]] : 1'b0;
    endfunction

    function automatic bit ratio_legal(input int r);
        return (r == 1) || (r == 2) || (r == 4);
    endfunction

    function automatic bit is_pow2(input int d);
        return (d > 0) && ((d & (d - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_clear_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bram_clear_seq: post-reset zero-fill sequencer, one word per cycle    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bram_clear_seq
    import qlf_bram_pkg::*;
#(
    parameter int DEPTH          = 4096,
    parameter int AW             = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] cnt,
    output logic          clr_we,
    output logic          busy
);

    localparam clr_state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    clr_state_t    r_state;
    clr_state_t    w_next;
    logic [AW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + AW'(1);
            end
        end
    end

    // READY is absorbing; only a reset can re-enter CLEAR.
    always_comb begin
        w_next = r_state;
        clr_we = 1'b0;
        busy   = 1'b0;
        if (r_state == CLEAR) begin
            clr_we = 1'b1;
            busy   = 1'b1;
            if (r_cnt == AW'(DEPTH - 1)) begin
                w_next = READY;
            end
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/bram_asym_wide_read_clr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bram_asym_wide_read_clr: narrow-write / RATIO-wide-read SDP RAM       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bram_asym_wide_read_clr
    import qlf_bram_pkg::*;
#(
    parameter  int WR_WIDTH       = 8,
    parameter  int WR_DEPTH       = 4096,
    parameter  int RATIO          = 4,
    parameter  int OUT_REG        = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int RD_WIDTH       = WR_WIDTH * RATIO,
    localparam int WA_W           = clog2(WR_DEPTH),
    localparam int RA_W           = WA_W - clog2(RATIO)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rce,
    input  logic [RA_W-1:0]     ra,
    output logic [RD_WIDTH-1:0] rq,
    output logic                rq_valid,
    input  logic                wce,
    input  logic [WA_W-1:0]     wa,
    input  logic [WR_WIDTH-1:0] wd,
    output logic                busy
);

    localparam int c_LANE_SHIFT = clog2(RATIO);

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("bram_asym_wide_read_clr: RATIO must be 1, 2 or 4");
    end
    if (!is_pow2(WR_DEPTH)) begin : g_bad_depth
        $error("bram_asym_wide_read_clr: WR_DEPTH must be a power of two");
    end
    if (!width_legal(WR_WIDTH)) begin : g_bad_width
        $error("bram_asym_wide_read_clr: WR_WIDTH not a supported width");
    end

    logic [WR_WIDTH-1:0] r_mem [WR_DEPTH];

    logic [WA_W-1:0]     w_clr_cnt;
    logic                w_clr_we;
    logic                w_busy;
    logic                w_we;
    logic [WA_W-1:0]     w_wa;
    logic [WR_WIDTH-1:0] w_wd;
    logic                w_rd_en;
    logic [RD_WIDTH-1:0] w_rd_word;
    logic [RD_WIDTH-1:0] r_s1;
    logic                r_v1;

    bram_clear_seq #(
        .DEPTH          (WR_DEPTH),
        .AW             (WA_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (w_clr_cnt),
        .clr_we (w_clr_we),
        .busy   (w_busy)
    );

    // The sequencer owns the write port while clearing; user requests are dropped.
    assign w_we    = w_clr_we | (wce & ~w_busy);
    assign w_wa    = w_clr_we ? w_clr_cnt : wa;
    assign w_wd    = w_clr_we ? '0 : wd;
    assign w_rd_en = rce & ~w_busy;
    assign busy    = w_busy;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
    end

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        logic [WA_W-1:0] w_addr;
        assign w_addr = (WA_W'(ra) << c_LANE_SHIFT) | WA_W'(k);
        assign w_rd_word[k*WR_WIDTH +: WR_WIDTH] = r_mem[w_addr];
    end

    // Sampling the array at the same edge as the write gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_en;
            if (w_rd_en) begin
                r_s1 <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [RD_WIDTH-1:0] r_s2;
        logic                r_v2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2 <= '0;
                r_v2 <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2 <= r_s1;
                end
            end
        end

        assign rq       = r_s2;
        assign rq_valid = r_v2;
    end else begin : g_no_out_reg
        assign rq       = r_s1;
        assign rq_valid = r_v1;
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_asym_wide_read_clr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bram_asym_wide_read_clr: scoreboard bench, two DUT configurations  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_bram_asym_wide_read_clr;

    typedef struct {
        logic [31:0] d;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // dut0: 8-bit write, x4 read, no output register, 4096 deep
    logic        rce0 = 1'b0, wce0 = 1'b0;
    logic [9:0]  ra0 = '0;
    logic [11:0] wa0 = '0;
    logic [7:0]  wd0 = '0;
    logic [31:0] rq0;
    logic        rq_valid0, busy0;

    // dut1: 16-bit write, x2 read, output register, 64 deep
    logic        rce1 = 1'b0, wce1 = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [5:0]  wa1 = '0;
    logic [15:0] wd1 = '0;
    logic [31:0] rq1;
    logic        rq_valid1, busy1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n0, n1;

    bram_asym_wide_read_clr #(
        .WR_WIDTH(8), .WR_DEPTH(4096), .RATIO(4), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .rce(rce0), .ra(ra0), .rq(rq0), .rq_valid(rq_valid0),
        .wce(wce0), .wa(wa0), .wd(wd0), .busy(busy0)
    );

    bram_asym_wide_read_clr #(
        .WR_WIDTH(16), .WR_DEPTH(64), .RATIO(2), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .rce(rce1), .ra(ra1), .rq(rq1), .rq_valid(rq_valid1),
        .wce(wce1), .wa(wa1), .wd(wd1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rq_valid0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rd0_unexpected: rq_valid with rq=%h, no read pending", rq0);
            end else begin
                e0 = q0.pop_front();
                if (rq0 !== e0.d || cyc != e0.at) begin
                    errors++;
                    $display("FAIL rd0_data: got %h at cycle %0d, expected %h at cycle %0d",
                             rq0, cyc, e0.d, e0.at);
                end
            end
        end
        if (rq_valid1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rd1_unexpected: rq_valid with rq=%h, no read pending", rq1);
            end else begin
                e1 = q1.pop_front();
                if (rq1 !== e1.d || cyc != e1.at) begin
                    errors++;
                    $display("FAIL rd1_data: got %h at cycle %0d, expected %h at cycle %0d",
                             rq1, cyc, e1.d, e1.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic op0(input logic r, input logic [9:0] a, input logic [31:0] exp,
                       input logic w, input logic [11:0] adr, input logic [7:0] d);
        rce0 = r; ra0 = a; wce0 = w; wa0 = adr; wd0 = d;
        @(posedge clk);
        #1;
        if (r) q0.push_back('{d: exp, at: cyc});
        rce0 = 1'b0; wce0 = 1'b0;
    endtask

    task automatic op1(input logic r, input logic [4:0] a, input logic [31:0] exp,
                       input logic w, input logic [5:0] adr, input logic [15:0] d);
        rce1 = r; ra1 = a; wce1 = w; wa1 = adr; wd1 = d;
        @(posedge clk);
        #1;
        if (r) q1.push_back('{d: exp, at: cyc + 1});
        rce1 = 1'b0; wce1 = 1'b0;
    endtask

    // Counts busy cycles on both DUTs while poking their ports, which must be ignored.
    task automatic count_busy(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy0) c0++;
            if (busy1) c1++;
            rce0 = (i >= 100 && i < 110); wce0 = rce0; ra0 = 10'd1; wa0 = 12'd5; wd0 = 8'hAA;
            rce1 = (i >= 10 && i < 20);   wce1 = rce1; ra1 = 5'd0;  wa1 = 6'd0;  wd1 = 16'hBEEF;
            if (!busy0 && !busy1) break;
        end
        rce0 = 1'b0; wce0 = 1'b0; rce1 = 1'b0; wce1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("reset_rq0", rq0, 32'h0);
        chk("reset_valid0", {31'h0, rq_valid0}, 32'h0);
        chk("reset_busy0", {31'h0, busy0}, 32'h1);
        chk("reset_rq1", rq1, 32'h0);
        chk("reset_valid1", {31'h0, rq_valid1}, 32'h0);
        chk("reset_busy1", {31'h0, busy1}, 32'h1);

        @(posedge clk); #2; rst_n = 1'b1;
        count_busy(n0, n1);
        chk("clear0_cycles", n0, 32'd4096);
        chk("clear1_cycles", n1, 32'd64);

        op0(1'b1, 10'd1, 32'h0000_0000, 1'b0, 12'd0, 8'h00);
        op1(1'b1, 5'd0,  32'h0000_0000, 1'b0, 6'd0, 16'h0000);

        op0(1'b0, 10'd0, 32'h0, 1'b1, 12'd8,  8'h01);
        op0(1'b0, 10'd0, 32'h0, 1'b1, 12'd9,  8'h02);
        op0(1'b0, 10'd0, 32'h0, 1'b1, 12'd10, 8'h03);
        op0(1'b0, 10'd0, 32'h0, 1'b1, 12'd11, 8'h04);
        op0(1'b1, 10'd2, 32'h0403_0201, 1'b0, 12'd0, 8'h00);

        op0(1'b1, 10'd1, 32'h0000_0000, 1'b1, 12'd5, 8'hCC);
        op0(1'b1, 10'd1, 32'h0000_CC00, 1'b0, 12'd0, 8'h00);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("hold0_rq", rq0, 32'h0000_CC00);
            chk("hold0_valid", {31'h0, rq_valid0}, 32'h0);
        end
        op0(1'b1, 10'd2, 32'h0403_0201, 1'b0, 12'd0, 8'h00);
        op0(1'b1, 10'd1, 32'h0000_CC00, 1'b0, 12'd0, 8'h00);

        op1(1'b0, 5'd0, 32'h0, 1'b1, 6'd0, 16'h1111);
        op1(1'b0, 5'd0, 32'h0, 1'b1, 6'd1, 16'h2222);
        op1(1'b1, 5'd0, 32'h2222_1111, 1'b0, 6'd0, 16'h0);
        op1(1'b0, 5'd0, 32'h0, 1'b1, 6'd2, 16'h3333);
        op1(1'b0, 5'd0, 32'h0, 1'b1, 6'd3, 16'h4444);
        op1(1'b1, 5'd1, 32'h4444_3333, 1'b0, 6'd0, 16'h0);
        op1(1'b1, 5'd0, 32'h2222_1111, 1'b0, 6'd0, 16'h0);
        op1(1'b0, 5'd0, 32'h0, 1'b0, 6'd0, 16'h0);
        op1(1'b1, 5'd1, 32'h4444_3333, 1'b0, 6'd0, 16'h0);
        repeat (2) @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("hold1_rq", rq1, 32'h4444_3333);
            chk("hold1_valid", {31'h0, rq_valid1}, 32'h0);
        end

        op0(1'b0, 10'd0, 32'h0, 1'b1, 12'd3001, 8'h5A);
        op0(1'b1, 10'd750, 32'h0000_5A00, 1'b0, 12'd0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset lands while dut1 holds a read in its first pipeline stage.
        rce1 = 1'b1; ra1 = 5'd0;
        @(posedge clk); #1;
        rce1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("flight_rq1", rq1, 32'h0);
        chk("flight_valid1", {31'h0, rq_valid1}, 32'h0);
        chk("flight_rq0", rq0, 32'h0);
        chk("flight_busy0", {31'h0, busy0}, 32'h1);

        @(posedge clk); #2; rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        #2;
        chk("midclear_busy0", {31'h0, busy0}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        count_busy(n0, n1);
        chk("reclear0_cycles", n0, 32'd4096);
        chk("reclear1_cycles", n1, 32'd64);

        op0(1'b1, 10'd750, 32'h0000_0000, 1'b0, 12'd0, 8'h00);
        op0(1'b1, 10'd2,   32'h0000_0000, 1'b0, 12'd0, 8'h00);
        op1(1'b1, 5'd0, 32'h0000_0000, 1'b0, 6'd0, 16'h0);
        op1(1'b1, 5'd1, 32'h0000_0000, 1'b0, 6'd0, 16'h0);
        repeat (4) @(negedge clk);

        chk("pending0", q0.size(), 32'd0);
        chk("pending1", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
